// File: rtl/mux_scan_serializer_pkg.sv
// ----------------------------------------------------------------------------
// mux_scan_serializer_pkg : shared state encoding, log2 and length clamp helper
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mux_scan_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DRAIN  = 2'd2,
    PARITY = 2'd3
  } state_e;

  // Number of bits needed to represent value (at least 1).
  function automatic int log2(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) <= value) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

  function automatic int clamp_len(input int len, input int width);
    if ((len == 0) || (len > width)) begin
      return width;
    end
    return len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_scan_serializer.sv
// ----------------------------------------------------------------------------
// mux_scan_serializer : drives an external WIDTH-bit bit-select mux LSB first
// and registers each selected bit onto a valid/ready serial stream.
// Optional macro SER_PARITY_EN appends an even-parity beat per word.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mux_scan_serializer
  import mux_scan_serializer_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int LOG_WIDTH = log2(WIDTH - 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [LOG_WIDTH:0]   in_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     mux_data,
  output logic [LOG_WIDTH-1:0] mux_sel,
  input  logic                 mux_out,
  output logic                 ser_bit,
  output logic                 ser_valid,
  input  logic                 ser_ready,
  output logic                 ser_last,
  output logic                 busy
);

  localparam int LW = LOG_WIDTH + 1;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mux_data_q, mux_data_d;
  logic [LOG_WIDTH-1:0] sel_q, sel_d;
  logic [LW-1:0]        len_q, len_d;
  logic                 settle_q, settle_d;
  logic                 ser_bit_q, ser_bit_d;
  logic                 ser_valid_q, ser_valid_d;
  logic                 ser_last_q, ser_last_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;
`ifdef SER_PARITY_EN
  logic                 par_q, par_d;
`endif

  logic          out_free;
  logic          last_idx;
  logic [LW-1:0] eff_len;

  assign eff_len  = LW'(clamp_len(int'(in_len), WIDTH));
  assign out_free = !ser_valid_q || ser_ready;
  assign last_idx = ({1'b0, sel_q} == (len_q - LW'(1)));

  always_comb begin
    state_d     = state_q;
    mux_data_d  = mux_data_q;
    sel_d       = sel_q;
    len_d       = len_q;
    settle_d    = 1'b0;
    ser_bit_d   = ser_bit_q;
    ser_valid_d = ser_valid_q;
    ser_last_d  = ser_last_q;
`ifdef SER_PARITY_EN
    par_d       = par_q;
`endif

    if (ser_valid_q && ser_ready) begin
      ser_valid_d = 1'b0;
      ser_last_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          mux_data_d = in_data;
          len_d      = eff_len;
          sel_d      = '0;
          // One cycle for the external mux to settle on the new word.
          settle_d   = 1'b1;
          state_d    = SHIFT;
`ifdef SER_PARITY_EN
          par_d      = 1'b0;
`endif
        end
      end

      SHIFT: begin
        if (!settle_q && out_free) begin
          ser_bit_d   = mux_out;
          ser_valid_d = 1'b1;
`ifdef SER_PARITY_EN
          par_d       = par_q ^ mux_out;
`endif
          if (last_idx) begin
`ifdef SER_PARITY_EN
            state_d    = PARITY;
`else
            ser_last_d = 1'b1;
            state_d    = DRAIN;
`endif
          end else begin
            sel_d = sel_q + LOG_WIDTH'(1);
          end
        end
      end

`ifdef SER_PARITY_EN
      PARITY: begin
        if (out_free) begin
          ser_bit_d   = par_q;
          ser_valid_d = 1'b1;
          ser_last_d  = 1'b1;
          state_d     = DRAIN;
        end
      end
`endif

      DRAIN: begin
        if (ser_valid_q && ser_ready && ser_last_q) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mux_data_q  <= '0;
      sel_q       <= '0;
      len_q       <= '0;
      settle_q    <= 1'b0;
      ser_bit_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mux_data_q  <= mux_data_d;
      sel_q       <= sel_d;
      len_q       <= len_d;
      settle_q    <= settle_d;
      ser_bit_q   <= ser_bit_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
`ifdef SER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign mux_data  = mux_data_q;
  assign mux_sel   = sel_q;
  assign ser_bit   = ser_bit_q;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_last_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: doc/mux_scan_serializer.md
Name: mux_scan_serializer

Overview:
- Sequencer that sits directly upstream of the WIDTH-bit bit-select mux and consumes its output.
- Accepts a parallel word and a bit count over a valid/ready handshake, then holds the word on the mux data bus.
- Steps the mux select from index 0 upward and registers each selected bit onto a valid/ready serial stream.
- The mux stays a separate instance; this block only drives its data/select inputs and reads its output.

Parameters:
- WIDTH, 64, parallel word width; equals the mux data width.
- LOG_WIDTH, log2(WIDTH-1), select width; computed with the shared log2 function.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_data  input  WIDTH  word to serialize.
- in_len  input  LOG_WIDTH+1  number of bits to send; 0 means WIDTH.
- in_valid  input  1  word offer.
- in_ready  output  1  block can accept a word.
- mux_data  output  WIDTH  held word, wired to the mux data input.
- mux_sel  output  LOG_WIDTH  bit index, wired to the mux select input.
- mux_out  input  1  selected bit, combinational return from the mux.
- ser_bit  output  1  serial data.
- ser_valid  output  1  ser_bit is valid.
- ser_ready  input  1  downstream accepts ser_bit.
- ser_last  output  1  marks the final beat of the word.
- busy  output  1  high whenever the block is not in IDLE.

Behaviour:
- Reset values: in_ready=0 while rst_n is low, then 1 (IDLE); mux_data=0, mux_sel=0, ser_bit=0, ser_valid=0, ser_last=0, busy=0.
- Reset mid-word drops the word immediately. No partial beat survives reset.
- States:
  - IDLE: in_ready=1. On in_valid, latch in_data into mux_data, latch the effective length (0 becomes WIDTH, values above WIDTH clamp to WIDTH), set mux_sel=0, go to SHIFT.
  - SHIFT: issue one index per cycle when the output register is free (ser_valid=0, or ser_valid=1 with ser_ready=1).
    - On an issue cycle, capture mux_out into ser_bit, set ser_valid=1, then increment mux_sel.
    - Set ser_last on the issue of index len-1, then go to DRAIN.
  - DRAIN: hold until the last beat is accepted (ser_valid & ser_ready & ser_last), then go to IDLE. ser_valid clears unless a new beat is captured.
- Stall rule: while ser_valid=1 and ser_ready=0, mux_sel, ser_bit and ser_last hold stable. No beat is skipped or duplicated.
- Latency: word accepted at edge T, first ser_valid at edge T+2. With ser_ready tied high, throughput is 1 bit per cycle and a len=N word occupies N+2 cycles from acceptance back to in_ready.
- Order: LSB first, index 0..len-1. mux_sel never exceeds len-1, so there is no wrap-around.
- len=1: a single beat with ser_last=1.
- in_ready=0 outside IDLE. in_valid held high during busy is ignored and not queued.
- ser_ready may toggle on any cycle, including on the last beat.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all sent data bits) is appended as one extra beat after index len-1.
  - ser_last moves from the last data beat to the parity beat.
  - A PARITY state sits between SHIFT and DRAIN; the parity accumulator clears on word acceptance.
- Undefined: no parity beat, no PARITY state, no accumulator logic.

Decomposition:
- Shared package:
  - log2 function.
  - State encoding constants: IDLE, SHIFT, DRAIN, PARITY.
  - Clamp helper for the effective-length calculation.
- No sub-module. The index counter and the output register are small enough to stay inline.
- The bit-select mux is instantiated beside this block at the level above, not inside it.

Test Plan:
- WIDTH=64, in_data=64'h0000_0000_0000_00A5, in_len=8, ser_ready=1 -> beats 1,0,1,0,0,1,0,1, ser_last on the 8th, in_ready back at T+10.
- in_len=0, in_data=all ones -> 64 beats of 1, ser_last on beat 64, mux_sel peaks at 63.
- in_len=4, ser_ready toggling 1,0,0,1,... -> exactly 4 beats, ser_bit/mux_sel stable on every stall cycle.
- rst_n pulsed low mid-word after 3 beats -> all outputs at reset values asynchronously; next word serializes from index 0.
- in_valid held high through a word -> the second word is accepted only in IDLE, with no beat overlap.
- SER_PARITY_EN defined, in_data=8'h07, in_len=8 -> 1,1,1,0,0,0,0,0 then parity beat 1 with ser_last.
